keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
//  Scans a ROWSxCOLS push-button matrix, debounces it, and emits press events as
//  one-cycle button_pressed pulses with a matching button_index.
//  Sits directly upstream of the cursor/display logic in the icestick min-OS, which
//  consumes button_pressed/button_index. Default 4x4 pad gives indices 0..15.
// PARAMETERS
//  ROWS            4     matrix rows (driven); ROWS*COLS <= 256
//  COLS            4     matrix columns (sensed)
//  SCAN_DIV        1200  CLK cycles each row is driven (100 us @ 12 MHz); must be >= 4
//  DEBOUNCE_SCANS  8     consecutive identical frames required before a state commits
//  REPEAT_DELAY    1250  frames from first press to first repeat (KEYPAD_AUTOREPEAT_EN only)
//  REPEAT_RATE     250   frames between subsequent repeats (KEYPAD_AUTOREPEAT_EN only)
// PORTS
//  CLK             in   1          system clock
//  RST             in   1          synchronous reset, active-high
//  row_drive       out  ROWS       active-low, one-hot-low row strobe
//  col_sense       in   COLS       raw async column inputs; active-low; pulled up off-chip
//  button_pressed  out  1          one-cycle pulse per press event
//  button_index    out  8          row*COLS+col, zero-extended; valid when button_pressed=1
//  button_held     out  1          level: 1 while any debounced key is down
// BEHAVIOUR
//  - Reset (RST high at a CLK edge):
//    - row_drive=~1 (row 0); row counter and divider=0.
//    - button_pressed=0, button_index=0, button_held=0.
//    - Snapshot, previous frame, debounced state, pending mask and stable count all 0.
//    - Reset mid-frame discards all partial data.
//    - A key held through reset is re-detected as a new press after debounce.
//  - col_sense passes through a 2-FF synchronizer; only the synced value is used.
//  - Row scanning:
//    - Divider counts 0..SCAN_DIV-1.
//    - On the terminal count, the synced column value for the current row is
//      inverted (1=pressed) and written into the snapshot bits [row*COLS +: COLS].
//    - The row then advances, wrapping ROWS-1 -> 0; row_drive updates on the same edge.
//  - Frame end (terminal count of row ROWS-1):
//    - If snapshot == previous frame, stable_cnt increments, saturating at DEBOUNCE_SCANS.
//    - Otherwise stable_cnt is set to 0.
//    - Previous frame <= snapshot.
//    - When stable_cnt reaches DEBOUNCE_SCANS: debounced <= snapshot, and
//      pending |= snapshot & ~debounced (newly pressed bits only).
//    - Releases never generate events.
//  - Event emission:
//    - Each cycle with pending != 0, button_pressed=1 for one cycle.
//    - button_index = lowest set pending bit; that bit clears on the same edge.
//    - Simultaneous presses therefore emit on consecutive cycles, ascending index.
//    - A pending bit whose key is released before emission is still emitted.
//  - Latency: first pulse 1 cycle after the committing frame-end edge.
//  - button_held = |debounced, registered; updates on the commit edge.
//  - button_pressed is never asserted on two cycles carrying the same index from
//    one press (macro off).
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined:
//   - While debounced has exactly one bit set, a frame counter runs from commit.
//   - At REPEAT_DELAY frames, that index is re-emitted via pending.
//   - Thereafter it is re-emitted every REPEAT_RATE frames.
//   - Counter clears on any debounced change, or when 0 or >=2 keys are held.
//  KEYPAD_AUTOREPEAT_EN undefined:
//   - Exactly one event per debounced press.
//   - No repeat counter logic is synthesized.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE_SCANS=3, 4x4, behavioural matrix model)
//  1. RST 2 cycles, no keys -> all outputs 0, row_drive=4'b1110,
//     4'b1101 after 4 cycles, back to 4'b1110 after 16.
//  2. Hold key r2c1 steady -> exactly one pulse, index 9, after 3 equal frames;
//     button_held=1; no further pulse for 20 frames; release -> held=0, no pulse.
//  3. Bounce r3c2 (alternate each frame) for 5 frames, then steady ->
//     single pulse index 14, only after 3 stable frames.
//  4. Press r0c1 and r3c2 in the same frame -> pulses on consecutive cycles,
//     index 1 then 14.
//  5. Hold r2c2, assert RST mid-frame for 1 cycle -> outputs 0;
//     key still held -> new pulse index 10 after debounce.
//  6. KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold index 10 ->
//     pulse at commit, +5 frames, then every 2 frames;
//     add second key -> repeats stop, only the new index pulses.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans a ROWS x COLS push-button matrix one row at a time, debounces whole
//   frames, and reports each new debounced press as a one-cycle button_pressed
//   pulse with button_index = row*COLS + col. Releases never produce events.
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     When defined, a single held key is re-emitted REPEAT_DELAY frames after
//     it commits and then every REPEAT_RATE frames. When undefined, no repeat
//     logic is built and each debounced press yields exactly one event.
module keypad_matrix_scanner #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1200,
  parameter int unsigned DEBOUNCE_SCANS = 8,
  parameter int unsigned REPEAT_DELAY   = 1250,
  parameter int unsigned REPEAT_RATE    = 250
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [ROWS-1:0] row_drive,
  input  logic [COLS-1:0] col_sense,
  output logic            button_pressed,
  output logic [7:0]      button_index,
  output logic            button_held
);

  localparam int unsigned KEYS  = ROWS * COLS;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1) + 1;

  // Reject parameter sets the index encoding or sampling pipeline cannot support.
  if ((KEYS > 256) || (ROWS < 1) || (COLS < 1) || (SCAN_DIV < 4) ||
      (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_cfg
    $error("keypad_matrix_scanner: unsupported parameter set");
  end

  logic [COLS-1:0]  col_meta;
  logic [COLS-1:0]  col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [KEYS-1:0]  snapshot;
  logic [KEYS-1:0]  prev_frame;
  logic [KEYS-1:0]  debounced;
  logic [KEYS-1:0]  pending;
  logic [STB_W-1:0] stable_cnt;

  logic             scan_tc_c;
  logic             frame_end_c;
  logic [ROW_W-1:0] row_next_c;
  logic [KEYS-1:0]  snap_next_c;
  logic [STB_W-1:0] stable_next_c;
  logic             commit_c;
  logic [KEYS-1:0]  new_press_c;
  logic [KEYS-1:0]  low_onehot_c;
  logic [7:0]       low_idx_c;
  logic [KEYS-1:0]  rep_add_c;
  logic [KEYS-1:0]  pending_next_c;

  // Two-flop synchronizer for the asynchronous column inputs (idle high).
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_sense;
      col_sync <= col_meta;
    end
  end

  // Row timing: terminal count of the divider and the row that follows.
  always_comb begin
    scan_tc_c   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    frame_end_c = scan_tc_c && (row_cnt == ROW_W'(ROWS - 1));
    if (row_cnt == ROW_W'(ROWS - 1)) begin
      row_next_c = '0;
    end else begin
      row_next_c = row_cnt + ROW_W'(1);
    end
  end

  // Divider, row counter and the active-low row strobe advance together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt   <= '0;
      row_cnt   <= '0;
      row_drive <= ~(ROWS'(1));
    end else if (scan_tc_c) begin
      div_cnt   <= '0;
      row_cnt   <= row_next_c;
      row_drive <= ~(ROWS'(1) << row_next_c);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Snapshot with the current row's inverted (1 = pressed) columns merged in.
  always_comb begin
    snap_next_c = snapshot;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_cnt == ROW_W'(r)) begin
        snap_next_c[r*COLS +: COLS] = ~col_sync;
      end
    end
  end

  // Frame-level debounce: count consecutive identical frames, saturating.
  always_comb begin
    if (snap_next_c == prev_frame) begin
      if (stable_cnt == STB_W'(DEBOUNCE_SCANS)) begin
        stable_next_c = stable_cnt;
      end else begin
        stable_next_c = stable_cnt + STB_W'(1);
      end
    end else begin
      stable_next_c = '0;
    end
    commit_c    = frame_end_c && (stable_next_c == STB_W'(DEBOUNCE_SCANS));
    new_press_c = snap_next_c & ~debounced;
  end

  // Snapshot capture, frame history, debounced state and held level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snapshot    <= '0;
      prev_frame  <= '0;
      debounced   <= '0;
      stable_cnt  <= '0;
      button_held <= 1'b0;
    end else begin
      if (scan_tc_c) begin
        snapshot <= snap_next_c;
      end
      if (frame_end_c) begin
        prev_frame <= snap_next_c;
        stable_cnt <= stable_next_c;
        if (commit_c) begin
          debounced   <= snap_next_c;
          button_held <= |snap_next_c;
        end
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_phase;
  logic [KEYS-1:0]  deb_next_c;
  logic             deb_single_c;
  logic             rep_clear_c;
  logic             rep_fire_c;

  // Repeat decision: only while exactly one key stays debounced-down unchanged.
  always_comb begin
    deb_next_c   = commit_c ? snap_next_c : debounced;
    deb_single_c = (deb_next_c != '0) && ((deb_next_c & (deb_next_c - KEYS'(1))) == '0);
    rep_clear_c  = (deb_next_c != debounced) || !deb_single_c;
    rep_fire_c   = 1'b0;
    if (frame_end_c && !rep_clear_c) begin
      if (rep_phase) begin
        rep_fire_c = ((rep_cnt + REP_W'(1)) == REP_W'(REPEAT_RATE));
      end else begin
        rep_fire_c = ((rep_cnt + REP_W'(1)) == REP_W'(REPEAT_DELAY));
      end
    end
    rep_add_c = rep_fire_c ? debounced : '0;
  end

  // Frame counter since the last commit; phase selects delay vs. rate interval.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (frame_end_c) begin
      if (rep_clear_c) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (rep_fire_c) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end
`else
  assign rep_add_c = '0;
`endif

  // Lowest pending key: one-hot isolate plus its binary index.
  always_comb begin
    low_onehot_c = pending & (~pending + KEYS'(1));
    low_idx_c    = '0;
    for (int i = int'(KEYS) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx_c = 8'(i);
      end
    end
    pending_next_c = (pending & ~low_onehot_c) | (commit_c ? new_press_c : '0) | rep_add_c;
  end

  // Event queue drains one key per cycle, ascending index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending        <= '0;
      button_pressed <= 1'b0;
      button_index   <= '0;
    end else begin
      pending        <= pending_next_c;
      button_pressed <= |pending;
      if (|pending) begin
        button_index <= low_idx_c;
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner (4x4, SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A frame-level reference model predicts events and held state from key history.
module tb_keypad_matrix_scanner;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned SDIV  = 4;
  localparam int unsigned DB    = 3;
  localparam int unsigned RD    = 5;
  localparam int unsigned RR    = 2;
  localparam int unsigned FRAME = ROWS * SDIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  row_drive;
  logic [3:0]  col_sense;
  logic        button_pressed;
  logic [7:0]  button_index;
  logic        button_held;
  logic [15:0] keys = '0;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLK(CLK), .RST(RST), .row_drive(row_drive), .col_sense(col_sense),
    .button_pressed(button_pressed), .button_index(button_index), .button_held(button_held)
  );

  always #5 CLK = ~CLK;

  // Matrix model: a pressed key in a strobed row pulls its column low.
  always_comb begin
    col_sense = '1;
    for (int r = 0; r < 4; r++) begin
      if (!row_drive[r]) col_sense = col_sense & ~keys[r*4 +: 4];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int obs_idx[$];
  int obs_cyc[$];
  int exp_q[$];
  logic [15:0] hist[$];
  logic [15:0] m_deb;
  int hold_frames;

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          exp_pulses;
    int          exp_first;
    int          exp_held;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(16'h0000);
    m_deb = '0;
    hold_frames = 0;
    exp_q.delete();
  endtask

  // Commit when the last DB+1 frames (including the implicit reset frame) agree.
  task automatic model_frame(input logic [15:0] k);
    logic [15:0] prev_deb;
    bit all_eq;
    prev_deb = m_deb;
    hist.push_back(k);
    while (hist.size() > DB + 1) void'(hist.pop_front());
    if (hist.size() == DB + 1) begin
      all_eq = 1'b1;
      foreach (hist[i]) if (hist[i] != k) all_eq = 1'b0;
      if (all_eq) begin
        for (int i = 0; i < 16; i++) if (k[i] && !m_deb[i]) exp_q.push_back(i);
        m_deb = k;
      end
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    if ((m_deb != prev_deb) || ($countones(m_deb) != 1)) begin
      hold_frames = 0;
    end else begin
      hold_frames++;
      if ((hold_frames == int'(RD)) ||
          ((hold_frames > int'(RD)) && (((hold_frames - int'(RD)) % int'(RR)) == 0))) begin
        for (int i = 0; i < 16; i++) if (m_deb[i]) exp_q.push_back(i);
      end
    end
`else
    if (m_deb != prev_deb) hold_frames = 0;
`endif
  endtask

  // Run n clock edges from a frame start, checking the row strobe and every pulse.
  task automatic run_span(input logic [15:0] k, input int n);
    logic [3:0] er;
    int e;
    keys = k;
    for (int j = 1; j <= n; j++) begin
      @(posedge CLK);
      #1;
      cyc++;
      er = '1;
      er[(j / int'(SDIV)) % int'(ROWS)] = 1'b0;
      check("row_drive", int'(row_drive), int'(er));
      if (button_pressed) begin
        pulse_cnt++;
        obs_idx.push_back(int'(button_index));
        obs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_index", int'(button_index), -1);
        end else begin
          e = exp_q.pop_front();
          check("pulse_index", int'(button_index), e);
        end
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] k);
    run_span(k, int'(FRAME));
    check("missed_pulses", exp_q.size(), 0);
    exp_q.delete();
    model_frame(k);
    check("button_held", int'(button_held), int'(m_deb != 0));
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc += n;
    model_reset();
    check("rst_row_drive", int'(row_drive), 4'b1110);
    check("rst_pressed", int'(button_pressed), 0);
    check("rst_index", int'(button_index), 0);
    check("rst_held", int'(button_held), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int p1;
    logic [15:0] rk;

    vecs[0] = '{16'h0200, 5, 1, 9, 1};
    vecs[1] = '{16'h0200, 3, 0, 0, 0};
    vecs[2] = '{16'h0200, 4, 1, 9, 1};
    vecs[3] = '{16'h0001, 5, 1, 0, 1};
    vecs[4] = '{16'h8000, 5, 1, 15, 1};
    vecs[5] = '{16'h4002, 5, 2, 1, 1};
    vecs[6] = '{16'hFFFF, 5, 16, 0, 1};
    vecs[7] = '{16'h0000, 5, 0, 0, 0};

    // Reset state and idle row rotation.
    do_reset(2);
    repeat (2) run_frame(16'h0000);

    // Table: hold a pattern, check held, release, count events.
    foreach (vecs[v]) begin
      p0 = pulse_cnt;
      repeat (vecs[v].hold) run_frame(vecs[v].keys);
      check("vec_held", int'(button_held), vecs[v].exp_held);
      repeat (6) run_frame(16'h0000);
      check("vec_pulses", pulse_cnt - p0, vecs[v].exp_pulses);
      if (vecs[v].exp_pulses > 0 && obs_idx.size() > p0)
        check("vec_first_index", obs_idx[p0], vecs[v].exp_first);
      check("vec_release_held", int'(button_held), 0);
    end

    // Long hold of r2c1, then release.
    p0 = pulse_cnt;
    repeat (24) run_frame(16'h0200);
    check("hold_held", int'(button_held), 1);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("hold_single_pulse", pulse_cnt - p0, 1);
`endif
    p1 = pulse_cnt;
    repeat (6) run_frame(16'h0000);
    check("release_no_pulse", pulse_cnt - p1, 0);
    check("release_held", int'(button_held), 0);

    // Bounce r3c2 for five frames, then steady.
    p0 = pulse_cnt;
    for (int f = 0; f < 5; f++) run_frame((f % 2 == 0) ? 16'h4000 : 16'h0000);
    repeat (3) run_frame(16'h4000);
    check("bounce_no_early_pulse", pulse_cnt - p0, 0);
    run_frame(16'h4000);
    check("bounce_one_pulse", pulse_cnt - p0, 1);
    if (obs_idx.size() > p0) check("bounce_index", obs_idx[p0], 14);
    repeat (6) run_frame(16'h0000);

    // Two keys in the same frame: consecutive cycles, ascending index.
    p0 = pulse_cnt;
    repeat (5) run_frame(16'h4002);
    check("dual_count", pulse_cnt - p0, 2);
    if (obs_idx.size() >= p0 + 2) begin
      check("dual_first", obs_idx[p0], 1);
      check("dual_second", obs_idx[p0 + 1], 14);
      check("dual_spacing", obs_cyc[p0 + 1] - obs_cyc[p0], 1);
    end
    repeat (6) run_frame(16'h0000);

    // Reset mid-frame with r2c2 held: re-detected as a fresh press.
    repeat (6) run_frame(16'h0400);
    run_span(16'h0400, 7);
    do_reset(1);
    p0 = pulse_cnt;
    repeat (4) run_frame(16'h0400);
    check("rst_redetect_none_yet", pulse_cnt - p0, 0);
    run_frame(16'h0400);
    check("rst_redetect_count", pulse_cnt - p0, 1);
    if (obs_idx.size() > p0) check("rst_redetect_index", obs_idx[p0], 10);
    repeat (6) run_frame(16'h0000);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat on a single held key, stopped by a second key.
    p0 = pulse_cnt;
    repeat (12) run_frame(16'h0400);
    check("repeat_count", pulse_cnt - p0, 3);
    repeat (4) run_frame(16'h0401);
    p1 = pulse_cnt;
    repeat (10) run_frame(16'h0401);
    check("repeat_stop_count", pulse_cnt - p1, 1);
    if (obs_idx.size() > p1) check("repeat_stop_index", obs_idx[p1], 0);
    repeat (6) run_frame(16'h0000);
`endif

    // Randomized key patterns held for random frame counts.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: rk = 16'h0000;
        1: rk = 16'(32'd1 << $urandom_range(0, 15));
        2: rk = 16'($urandom & $urandom);
        default: rk = 16'($urandom & $urandom & $urandom);
      endcase
      repeat ($urandom_range(1, 6)) run_frame(rk);
    end
    repeat (6) run_frame(16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
